// File: rtl/inst_fetch_queue.sv
// inst_fetch_queue: instruction-fetch front end with several requests in flight.
// Issued PCs wait in a small queue until their instruction returns. Returned
// {pc, inst} pairs are buffered in a FIFO that drains to the decode stage.
// A redirect flushes the FIFO, marks every in-flight response as stale, and
// restarts fetch at the new PC.

// Invariant checker for the fetch queue's internal counters.
module inst_fetch_queue_chk #(
    parameter int DEPTH   = 4,
    parameter int MAX_OUT = 2,
    parameter int OUT_W   = 2,
    parameter int CNT_W   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [OUT_W-1:0] out_q,
    input  logic [OUT_W-1:0] cancel_q,
    input  logic [CNT_W-1:0] count_q,
    input  logic             inst_data_ok
);
    localparam logic [31:0] DEPTH_L   = 32'(DEPTH);
    localparam logic [31:0] MAX_OUT_L = 32'(MAX_OUT);

    a_cancel_le_out : assert property (@(posedge clk) disable iff (reset)
        32'(cancel_q) <= 32'(out_q));
    a_out_le_max : assert property (@(posedge clk) disable iff (reset)
        32'(out_q) <= MAX_OUT_L);
    a_count_le_depth : assert property (@(posedge clk) disable iff (reset)
        32'(count_q) <= DEPTH_L);
    a_no_orphan_data : assert property (@(posedge clk) disable iff (reset)
        !(inst_data_ok && (out_q == OUT_W'(0))));
endmodule

module inst_fetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'hbfc00000)
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   inst_req,
    output logic [ADDR_W-1:0]      inst_addr,
    input  logic                   inst_addr_ok,
    input  logic                   inst_data_ok,
    input  logic [DATA_W-1:0]      inst_rdata,
    input  logic                   redirect_valid,
    input  logic [ADDR_W-1:0]      redirect_pc,
    output logic                   fq_to_ds_valid,
    output logic [ADDR_W-1:0]      fq_to_ds_pc,
    output logic [DATA_W-1:0]      fq_to_ds_inst,
    input  logic                   ds_allowin,
    output logic [$clog2(DEPTH):0] fq_count
);
    localparam int          AW        = $clog2(DEPTH);
    localparam int          CNT_W     = AW + 1;
    localparam int          OUT_W     = $clog2(MAX_OUT + 1);
    localparam int          PQ_AW     = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [31:0] DEPTH_L   = 32'(DEPTH);
    localparam logic [31:0] MAX_OUT_L = 32'(MAX_OUT);

    // Fetch and bookkeeping state.
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [OUT_W-1:0]  out_q, out_d;          // all in-flight requests, stale included
    logic [OUT_W-1:0]  cancel_q, cancel_d;    // in-flight responses still to discard
    logic [PQ_AW-1:0]  pq_rd_q, pq_rd_d, pq_wr_q, pq_wr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;

    // Storage; contents are only meaningful under the pointers/counters.
    logic [ADDR_W-1:0] pq_mem    [MAX_OUT];
    logic [ADDR_W-1:0] fifo_pc   [DEPTH];
    logic [DATA_W-1:0] fifo_inst [DEPTH];

    logic inst_req_s, accept_s, discard_s, keep_s, pop_s;

    // Advance a PC-queue pointer, wrapping at MAX_OUT (need not be a power of two).
    function automatic logic [PQ_AW-1:0] pq_inc(input logic [PQ_AW-1:0] p);
        if (p == PQ_AW'(MAX_OUT - 1)) begin
            return PQ_AW'(0);
        end else begin
            return p + PQ_AW'(1);
        end
    endfunction

    // Issue gate: outstanding plus buffered never exceeds DEPTH, so every
    // response that comes back has a FIFO slot waiting for it.
    always_comb begin
        inst_req_s = 1'b0;
        if (!reset && !redirect_valid && (32'(out_q) < MAX_OUT_L) &&
            ((32'(out_q) + 32'(count_q)) < DEPTH_L)) begin
            inst_req_s = 1'b1;
        end else begin
            inst_req_s = 1'b0;
        end
    end

    // Per-cycle events: accept, discard or keep of a response, and ID pop.
    always_comb begin
        accept_s  = inst_req_s & inst_addr_ok;
        discard_s = inst_data_ok & (cancel_q != OUT_W'(0));
        keep_s    = inst_data_ok & (cancel_q == OUT_W'(0)) & ~redirect_valid;
        pop_s     = (count_q != CNT_W'(0)) & ds_allowin;
    end

    // Next state for fetch PC, in-flight counters and the PC queue.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        out_d      = out_q;
        cancel_d   = cancel_q;
        pq_wr_d    = pq_wr_q;
        pq_rd_d    = pq_rd_q;

        if (accept_s && !inst_data_ok) begin
            out_d = out_q + OUT_W'(1);
        end else if (!accept_s && inst_data_ok) begin
            out_d = out_q - OUT_W'(1);
        end else begin
            out_d = out_q;
        end

        // A redirect turns everything still in flight into a response to drop.
        if (redirect_valid) begin
            cancel_d = out_d;
        end else if (discard_s) begin
            cancel_d = cancel_q - OUT_W'(1);
        end else begin
            cancel_d = cancel_q;
        end

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
        end else if (accept_s) begin
            fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end else begin
            fetch_pc_d = fetch_pc_q;
        end

        // Stale responses still consume their PC-queue slot.
        if (accept_s) begin
            pq_wr_d = pq_inc(pq_wr_q);
        end else begin
            pq_wr_d = pq_wr_q;
        end
        if (inst_data_ok) begin
            pq_rd_d = pq_inc(pq_rd_q);
        end else begin
            pq_rd_d = pq_rd_q;
        end
    end

    // Next state for FIFO occupancy and pointers; a redirect empties it.
    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (redirect_valid) begin
            count_d  = CNT_W'(0);
            rd_ptr_d = AW'(0);
            wr_ptr_d = AW'(0);
        end else begin
            wr_ptr_d = keep_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
            rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
            case ({keep_s, pop_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
            out_q      <= OUT_W'(0);
            cancel_q   <= OUT_W'(0);
            pq_rd_q    <= PQ_AW'(0);
            pq_wr_q    <= PQ_AW'(0);
            count_q    <= CNT_W'(0);
            rd_ptr_q   <= AW'(0);
            wr_ptr_q   <= AW'(0);
        end else begin
            fetch_pc_q <= fetch_pc_d;
            out_q      <= out_d;
            cancel_q   <= cancel_d;
            pq_rd_q    <= pq_rd_d;
            pq_wr_q    <= pq_wr_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Data storage writes: issued PC on accept, {pc, inst} on a kept response.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            pq_mem[pq_wr_q] <= fetch_pc_q;
        end
        if (keep_s) begin
            fifo_pc[wr_ptr_q]   <= pq_mem[pq_rd_q];
            fifo_inst[wr_ptr_q] <= inst_rdata;
        end
    end

    assign inst_req       = inst_req_s;
    assign inst_addr      = fetch_pc_q;
    assign fq_to_ds_valid = (count_q != CNT_W'(0));
    assign fq_to_ds_pc    = fifo_pc[rd_ptr_q];
    assign fq_to_ds_inst  = fifo_inst[rd_ptr_q];
    assign fq_count       = count_q;

    inst_fetch_queue_chk #(
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT),
        .OUT_W   (OUT_W),
        .CNT_W   (CNT_W)
    ) u_chk (
        .clk          (clk),
        .reset        (reset),
        .out_q        (out_q),
        .cancel_q     (cancel_q),
        .count_q      (count_q),
        .inst_data_ok (inst_data_ok)
    );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: an in-order SRAM-like slave model plus a
// scoreboard of expected {pc, inst} pairs, checked whenever ID pops.
module tb_inst_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;
    localparam logic [31:0] RESET_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        reset, inst_req, inst_addr_ok, inst_data_ok, redirect_valid;
    logic        fq_to_ds_valid, ds_allowin;
    logic [31:0] inst_addr, inst_rdata, redirect_pc, fq_to_ds_pc, fq_to_ds_inst;
    logic [2:0]  fq_count;

    inst_fetch_queue #(.ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT),
                       .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .inst_req(inst_req), .inst_addr(inst_addr),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .fq_to_ds_valid(fq_to_ds_valid), .fq_to_ds_pc(fq_to_ds_pc),
        .fq_to_ds_inst(fq_to_ds_inst), .ds_allowin(ds_allowin), .fq_count(fq_count));

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int ep; int due; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

    req_t        slv[$];      // requests accepted by the slave, in order
    exp_t        sb[$];       // expected FIFO contents
    logic [31:0] acc_log[$];
    logic [31:0] pop_log[$];
    logic [31:0] exp_pc;
    int total = 0, bad = 0, cyc = 0, epoch = 0, lat = 1;
    int n_acc = 0, n_pop = 0, first_acc = -1, first_vld = -1, n_pushpop_full = 0;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h00a5_5a00;
    endfunction

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs at the negedge: checks outputs, then mirrors the coming clock edge.
    task automatic observe();
        exp_t e;
        req_t r;
        int   pre;
        logic exp_req, popped;
        if (reset) begin
            check_val("req_in_reset", 64'(inst_req), 64'd0);
            slv.delete(); sb.delete(); exp_pc = RESET_PC;
            return;
        end
        pre = sb.size();
        check_val("fq_count", 64'(fq_count), 64'(pre));
        check_val("fq_valid", 64'(fq_to_ds_valid), 64'(pre != 0));
        exp_req = !redirect_valid && (slv.size() < MAX_OUT) && (slv.size() + pre < DEPTH);
        check_val("inst_req", 64'(inst_req), 64'(exp_req));
        if (fq_to_ds_valid && first_vld < 0) first_vld = cyc;
        if (inst_req && inst_addr_ok) begin
            check_val("inst_addr", 64'(inst_addr), 64'(exp_pc));
            r.addr = exp_pc; r.ep = epoch; r.due = cyc + lat;
            slv.push_back(r);
            acc_log.push_back(inst_addr);
            exp_pc = exp_pc + 32'd4;
            n_acc++;
            if (first_acc < 0) first_acc = cyc;
        end
        popped = 1'b0;
        if (fq_to_ds_valid && ds_allowin) begin
            if (sb.size() == 0) begin
                check_val("pop_unexpected", 64'(fq_to_ds_valid), 64'd0);
            end else begin
                e = sb.pop_front();
                check_val("pop_pc", 64'(fq_to_ds_pc), 64'(e.pc));
                check_val("pop_inst", 64'(fq_to_ds_inst), 64'(e.inst));
                pop_log.push_back(fq_to_ds_pc);
                n_pop++;
                popped = 1'b1;
            end
        end
        if (inst_data_ok && slv.size() != 0) begin
            r = slv.pop_front();
            if (r.ep == epoch && !redirect_valid) begin
                e.pc = r.addr; e.inst = inst_of(r.addr);
                sb.push_back(e);
                if (popped && pre == DEPTH - 1) n_pushpop_full++;
            end
        end
        if (redirect_valid) begin
            epoch++;
            sb.delete();
            exp_pc = redirect_pc;
        end
    endtask

    // Slave response drive for the new cycle: head returns once due.
    task automatic drive();
        if (slv.size() != 0 && slv[0].due <= cyc) begin
            inst_data_ok = 1'b1; inst_rdata = inst_of(slv[0].addr);
        end else begin
            inst_data_ok = 1'b0; inst_rdata = 32'h0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic do_reset();
        reset = 1'b1; redirect_valid = 1'b0;
        repeat (2) cycle();
        reset = 1'b0;
        drive();
        acc_log.delete(); pop_log.delete();
        n_acc = 0; n_pop = 0; first_acc = -1; first_vld = -1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int found;
        reset = 1'b1; inst_addr_ok = 1'b1; inst_data_ok = 1'b0; inst_rdata = 32'h0;
        redirect_valid = 1'b0; redirect_pc = 32'h0; ds_allowin = 1'b1;
        @(posedge clk); #1;

        // Reset values, then a free-running stream.
        do_reset();
        check_val("rst_count", 64'(fq_count), 64'd0);
        check_val("rst_valid", 64'(fq_to_ds_valid), 64'd0);
        check_val("rst_addr", 64'(inst_addr), 64'(RESET_PC));
        lat = 1; ds_allowin = 1'b1;
        repeat (20) cycle();
        check_val("first_valid_latency", 64'(first_vld - first_acc), 64'd2);
        check_val("stream_pc0", 64'(pop_log[0]), 64'h bfc00000);
        check_val("stream_pc1", 64'(pop_log[1]), 64'h bfc00004);

        // Back-pressure: exactly DEPTH accepts, then resume after a pop.
        do_reset();
        ds_allowin = 1'b0;
        repeat (12) cycle();
        check_val("bp_accepts", 64'(n_acc), 64'(DEPTH));
        check_val("bp_count", 64'(fq_count), 64'(DEPTH));
        check_val("bp_req", 64'(inst_req), 64'd0);
        ds_allowin = 1'b1;
        cycle();
        check_val("bp_resume_req", 64'(inst_req), 64'd1);

        // Redirect with two requests in flight and a non-empty FIFO.
        do_reset();
        ds_allowin = 1'b0; lat = 3; found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (slv.size() == 2 && sb.size() >= 1) found = 1;
            else cycle();
        end
        check_val("rd1_setup", 64'(found), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 32'hbfc00100;
        cycle();
        redirect_valid = 1'b0;
        check_val("rd1_flush", 64'(fq_count), 64'd0);
        ds_allowin = 1'b1; lat = 1;
        acc_log.delete(); pop_log.delete();
        repeat (15) cycle();
        check_val("rd1_first_req", 64'(acc_log[0]), 64'h bfc00100);
        check_val("rd1_first_pop", 64'(pop_log[0]), 64'h bfc00100);

        // Stale data_ok coinciding with a second redirect while one request is live.
        do_reset();
        ds_allowin = 1'b0; lat = 3;
        cycle();
        lat = 8;
        cycle();
        redirect_valid = 1'b1; redirect_pc = 32'hbfc00100;
        cycle();
        redirect_valid = 1'b0; found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (inst_data_ok && slv.size() == 2 && slv[0].ep != epoch && slv[1].ep == epoch)
                found = 1;
            else cycle();
        end
        check_val("rd2_setup", 64'(found), 64'd1);
        redirect_valid = 1'b1; redirect_pc = 32'hbfc00200; lat = 1;
        acc_log.delete(); pop_log.delete();
        cycle();
        redirect_valid = 1'b0; ds_allowin = 1'b1;
        repeat (25) cycle();
        check_val("rd2_first_req", 64'(acc_log[0]), 64'h bfc00200);
        check_val("rd2_first_pop", 64'(pop_log[0]), 64'h bfc00200);

        // Address wrap at the top of the address space.
        redirect_valid = 1'b1; redirect_pc = 32'hfffffffc;
        acc_log.delete();
        cycle();
        redirect_valid = 1'b0;
        repeat (10) cycle();
        check_val("wrap_req0", 64'(acc_log[0]), 64'h fffffffc);
        check_val("wrap_req1", 64'(acc_log[1]), 64'h00000000);

        // Push and pop together at DEPTH-1, then random traffic over several laps.
        do_reset();
        ds_allowin = 1'b0; lat = 2; found = 0;
        for (int i = 0; i < 20 && found == 0; i++) begin
            if (sb.size() == DEPTH - 1 && inst_data_ok) found = 1;
            else cycle();
        end
        check_val("pp_setup", 64'(found), 64'd1);
        ds_allowin = 1'b1; n_pushpop_full = 0;
        cycle();
        check_val("pp_count", 64'(fq_count), 64'(DEPTH - 1));
        check_val("pp_events", 64'(n_pushpop_full), 64'd1);
        n_pop = 0;
        for (int i = 0; i < 80; i++) begin
            ds_allowin   = 1'($urandom_range(0, 1));
            inst_addr_ok = 1'($urandom_range(0, 1));
            lat          = int'($urandom_range(1, 3));
            cycle();
        end
        inst_addr_ok = 1'b1;
        check_val("laps_pops", 64'(n_pop >= 3 * DEPTH), 64'd1);

        // Reset in the middle of traffic.
        do_reset();
        ds_allowin = 1'b0; lat = 4; found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            if (slv.size() == 1 && sb.size() == 3) found = 1;
            else cycle();
        end
        check_val("mid_rst_setup", 64'(found), 64'd1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        drive();
        check_val("mid_rst_count", 64'(fq_count), 64'd0);
        check_val("mid_rst_valid", 64'(fq_to_ds_valid), 64'd0);
        check_val("mid_rst_addr", 64'(inst_addr), 64'(RESET_PC));
        ds_allowin = 1'b1; lat = 1;
        pop_log.delete();
        repeat (10) cycle();
        check_val("mid_rst_first_pop", 64'(pop_log[0]), 64'(RESET_PC));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
